// File: rtl/mda_video_out.sv
// MDA output stage: 2-cycle pixel pipe with palette lookup and matched sync delay,
// plus a sync-timing measurement FSM reporting line length, frame height and lock.
module mda_video_out #(
    parameter int H_CNT_W = 12,
    parameter int V_CNT_W = 10,
    parameter int TIMEOUT = 4000
) (
    input  logic               clk,
    input  logic               reset_l,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               de_in,
    input  logic               video_in,
    input  logic               intensity_in,
    input  logic [1:0]         palette,
    output logic [7:0]         r,
    output logic [7:0]         g,
    output logic [7:0]         b,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o,
    output logic [H_CNT_W-1:0] line_clocks,
    output logic [V_CNT_W-1:0] frame_lines,
    output logic               locked,
    output logic               fsm_state
);

    typedef enum logic {WAIT_V = 1'b0, MEASURE = 1'b1} state_t;

    localparam logic [H_CNT_W-1:0] H_MAX = {H_CNT_W{1'b1}};
    localparam logic [V_CNT_W-1:0] V_MAX = {V_CNT_W{1'b1}};

    state_t             state;
    logic               hs_prev, vs_prev;
    logic               s1_hs, s1_vs, s1_de, s1_video, s1_int;
    logic [1:0]         active_pal;
    logic [23:0]        normal, bright, pix_rgb;
    logic [H_CNT_W-1:0] hcnt, prev_clocks, clocks_now;
    logic [V_CNT_W-1:0] vcnt, prev_lines, lines_now, vcnt_inc;
    logic               prev_valid;
    logic               hs_rise, vs_rise, timeout;

    assign hs_rise  = hsync_in & ~hs_prev;
    assign vs_rise  = vsync_in & ~vs_prev;
    assign timeout  = (hcnt == H_CNT_W'(TIMEOUT));
    assign vcnt_inc = (vcnt == V_MAX) ? vcnt : vcnt + V_CNT_W'(1);
    // A coincident hsync rise is counted before the frame is latched.
    assign lines_now  = hs_rise ? vcnt_inc : vcnt;
    assign clocks_now = hs_rise ? hcnt : line_clocks;
    assign fsm_state  = state;

    always_comb begin
        normal = 24'h00AA00;
        bright = 24'h00FF00;
        case (active_pal)
            2'd1:    begin normal = 24'hAA6E00; bright = 24'hFFB000; end
            2'd2:    begin normal = 24'hAAAAAA; bright = 24'hFFFFFF; end
            2'd3:    begin normal = 24'hC0C0C0; bright = 24'hFFFFFF; end
            default: ;
        endcase
        if (!s1_de || !s1_video) pix_rgb = 24'h000000;
        else if (s1_int)         pix_rgb = bright;
        else                     pix_rgb = normal;
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            s1_hs      <= 1'b0;
            s1_vs      <= 1'b0;
            s1_de      <= 1'b0;
            s1_video   <= 1'b0;
            s1_int     <= 1'b0;
            r          <= 8'd0;
            g          <= 8'd0;
            b          <= 8'd0;
            hsync_o    <= 1'b0;
            vsync_o    <= 1'b0;
            de_o       <= 1'b0;
            active_pal <= 2'd0;
        end else begin
            s1_hs      <= hsync_in;
            s1_vs      <= vsync_in;
            s1_de      <= de_in;
            s1_video   <= video_in;
            s1_int     <= intensity_in;
            {r, g, b}  <= pix_rgb;
            hsync_o    <= s1_hs;
            vsync_o    <= s1_vs;
            de_o       <= s1_de;
            // Palette only switches at frame start so a change never tears.
            if (vs_rise) active_pal <= palette;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state       <= WAIT_V;
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            line_clocks <= '0;
            frame_lines <= '0;
            locked      <= 1'b0;
            prev_lines  <= '0;
            prev_clocks <= '0;
            prev_valid  <= 1'b0;
        end else begin
            hs_prev <= hsync_in;
            vs_prev <= vsync_in;
            if (hs_rise)           hcnt <= H_CNT_W'(1);
            else if (hcnt != H_MAX) hcnt <= hcnt + H_CNT_W'(1);
            vcnt <= vs_rise ? '0 : lines_now;

            if (timeout) begin
                state       <= WAIT_V;
                locked      <= 1'b0;
                line_clocks <= '0;
                frame_lines <= '0;
                prev_valid  <= 1'b0;
            end else begin
                case (state)
                    WAIT_V: begin
                        if (vs_rise) state <= MEASURE;
                    end
                    MEASURE: begin
                        if (hs_rise) line_clocks <= hcnt;
                        if (vs_rise) begin
                            frame_lines <= lines_now;
                            prev_lines  <= lines_now;
                            prev_clocks <= clocks_now;
                            prev_valid  <= 1'b1;
                            locked      <= prev_valid && (lines_now == prev_lines) &&
                                           (clocks_now == prev_clocks);
                        end
                    end
                    default: state <= WAIT_V;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mda_video_out.sv
// Bench for mda_video_out: per-cycle pixel-pipe model check plus directed
// measurement/lock/timeout vectors with hand-computed expectations.
module tb_mda_video_out;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, de_in = 1'b0;
    logic        video_in = 1'b0, intensity_in = 1'b0;
    logic [1:0]  palette = 2'd0;
    logic [7:0]  r, g, b;
    logic        hsync_o, vsync_o, de_o, locked, fsm_state;
    logic [11:0] line_clocks;
    logic [9:0]  frame_lines;

    int checks = 0;
    int errors = 0;

    localparam logic [23:0] NRM_TAB [4] = '{24'h00AA00, 24'hAA6E00, 24'hAAAAAA, 24'hC0C0C0};
    localparam logic [23:0] BRT_TAB [4] = '{24'h00FF00, 24'hFFB000, 24'hFFFFFF, 24'hFFFFFF};

    mda_video_out dut (
        .clk(clk), .reset_l(reset_l), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .de_in(de_in), .video_in(video_in), .intensity_in(intensity_in),
        .palette(palette), .r(r), .g(g), .b(b), .hsync_o(hsync_o),
        .vsync_o(vsync_o), .de_o(de_o), .line_clocks(line_clocks),
        .frame_lines(frame_lines), .locked(locked), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] colour(input logic [1:0] p, input logic d,
                                           input logic v, input logic i);
        if (!d || !v) return 24'h000000;
        return i ? BRT_TAB[p] : NRM_TAB[p];
    endfunction

    // Model: {rgb, hsync, vsync, de} expected two edges after the inputs are sampled.
    logic [26:0] d1 = '0, d2 = '0;
    logic        vs_last = 1'b0;
    logic [1:0]  pal_m = 2'd0;
    logic        started = 1'b0;

    always @(posedge clk) begin
        logic [1:0] pal_n;
        if (!reset_l) begin
            d1 <= '0; d2 <= '0; vs_last <= 1'b0; pal_m <= 2'd0; started <= 1'b1;
        end else begin
            pal_n = (vsync_in && !vs_last) ? palette : pal_m;
            pal_m <= pal_n;
            d2 <= d1;
            d1 <= {colour(pal_n, de_in, video_in, intensity_in), hsync_in, vsync_in, de_in};
            vs_last <= vsync_in;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if ({r, g, b, hsync_o, vsync_o, de_o} !== d2) begin
                errors++;
                $display("FAIL pixpipe got %h required %h at %0t",
                         {r, g, b, hsync_o, vsync_o, de_o}, d2, $time);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic hs, input logic vs, input logic de,
                         input logic vid, input logic inten, input logic [1:0] pal);
        hsync_in = hs; vsync_in = vs; de_in = de;
        video_in = vid; intensity_in = inten; palette = pal;
        @(posedge clk);
        #1;
    endtask

    task automatic check_meas(input string name, input logic [11:0] e_lc,
                              input logic [9:0] e_fl, input logic e_lk, input logic e_st);
        check({name, "_line_clocks"}, 32'(line_clocks), 32'(e_lc));
        check({name, "_frame_lines"}, 32'(frame_lines), 32'(e_fl));
        check({name, "_locked"},      32'(locked),      32'(e_lk));
        check({name, "_fsm"},         32'(fsm_state),   32'(e_st));
    endtask

    // One frame of 100-clock lines; vsync rise coincides with line 0's hsync rise.
    task automatic run_frame(input string name, input int lines, input logic [1:0] pal,
                             input logic [11:0] e_lc, input logic [9:0] e_fl,
                             input logic e_lk);
        for (int ln = 0; ln < lines; ln++) begin
            for (int px = 0; px < 100; px++) begin
                drive(px < 8, ln < 2, (px >= 16) && (px < 92) && (ln >= 3),
                      ((px + ln) % 3) != 0, ((px >> 3) & 1) == 1, pal);
                if (ln == 0 && px == 50) check_meas(name, e_lc, e_fl, e_lk, 1'b1);
            end
        end
    endtask

    initial begin
        // Reset held with toggling inputs.
        reset_l = 1'b0;
        for (int i = 0; i < 5; i++)
            drive(i[0], i[1], 1'b1, 1'b1, ~i[0], 2'(i));
        check("rst_rgb", 32'({r, g, b}), 32'h0);
        check("rst_syncs", 32'({hsync_o, vsync_o, de_o}), 32'h0);
        check_meas("rst", 12'd0, 10'd0, 1'b0, 1'b0);
        reset_l = 1'b1;
        drive(0, 0, 0, 0, 0, 2'd0);

        // Pixel path latency and colour rules, palette 0.
        drive(1, 0, 1, 1, 1, 2'd0);
        check("pix_lat1", 32'({r, g, b}), 32'h0);
        drive(0, 0, 0, 1, 1, 2'd0);
        check("pix_bright", 32'({r, g, b}), 32'h00FF00);
        check("pix_hs", 32'({hsync_o, de_o}), 32'b11);
        drive(0, 0, 1, 0, 1, 2'd0);
        check("pix_de0", 32'({r, g, b}), 32'h0);
        check("pix_hs0", 32'(hsync_o), 32'h0);
        drive(0, 0, 1, 1, 0, 2'd0);
        check("pix_int_only", 32'({r, g, b}), 32'h0);
        drive(0, 0, 0, 0, 0, 2'd0);
        check("pix_normal", 32'({r, g, b}), 32'h00AA00);

        // Palette change only takes effect at a vsync rise.
        drive(0, 0, 1, 1, 0, 2'd1);
        drive(0, 1, 1, 1, 0, 2'd1);
        check("pal_hold", 32'({r, g, b}), 32'h00AA00);
        drive(0, 1, 1, 1, 1, 2'd3);
        check("pal_amber", 32'({r, g, b}), 32'hAA6E00);
        check("pal_vs", 32'(vsync_o), 32'h1);
        drive(0, 0, 0, 0, 0, 2'd3);
        check("pal_amber_brt", 32'({r, g, b}), 32'hFFB000);

        // Mid-frame reset flushes the pipe and measurement.
        reset_l = 1'b0;
        drive(1, 1, 1, 1, 1, 2'd2);
        check("mid_rst_rgb", 32'({r, g, b, hsync_o, vsync_o, de_o}), 32'h0);
        drive(0, 0, 1, 1, 1, 2'd2);
        check_meas("mid_rst", 12'd0, 10'd0, 1'b0, 1'b0);
        reset_l = 1'b1;
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 2'd0);

        // Lock acquisition, a mismatching frame, and recovery.
        run_frame("f1", 49, 2'd2, 12'd0,   10'd0,  1'b0);
        run_frame("f2", 49, 2'd3, 12'd100, 10'd49, 1'b0);
        run_frame("f3", 49, 2'd1, 12'd100, 10'd49, 1'b1);
        run_frame("f4", 48, 2'd0, 12'd100, 10'd49, 1'b1);
        run_frame("f5", 49, 2'd2, 12'd100, 10'd48, 1'b0);
        run_frame("f6", 49, 2'd1, 12'd100, 10'd49, 1'b0);
        run_frame("f7", 2,  2'd0, 12'd100, 10'd49, 1'b1);

        // Sync loss: still locked just short of the timeout, cleared after it.
        for (int i = 0; i < 3800; i++) drive(0, 0, 0, 0, 0, 2'd0);
        check_meas("pre_to", 12'd100, 10'd49, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) drive(0, 0, 0, 0, 0, 2'd0);
        check_meas("post_to", 12'd0, 10'd0, 1'b0, 1'b0);

        // Resume: lock again after two full frames.
        run_frame("g1", 49, 2'd3, 12'd0,   10'd0,  1'b0);
        run_frame("g2", 49, 2'd0, 12'd100, 10'd49, 1'b0);
        run_frame("g3", 2,  2'd1, 12'd100, 10'd49, 1'b1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
